uart_tx_arbiter: RTL and testbench

- Round-robin arbiter/sequencer sharing one uart_transmitter among N_REQ byte producers.
- Selects a requester, launches its byte with a single-cycle data-valid pulse, then waits for the transmitter's done pulse before granting again.
- Sits between on-chip byte sources (status reporters, debug streams) and the transmitter's i_tx_dv / i_tx_Byte / tx_done interface.

---
 rtl/uart_tx_arbiter.sv | 119 +++++++++++
 tb/tb_uart_tx_arbiter.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one UART transmitter among N_REQ byte producers.
// Optional WAIT_DONE watchdog is compiled in with `define UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter #(
  parameter int N_REQ        = 4,
  parameter int TIMEOUT_CLKS = 2048
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic [N_REQ-1:0]         i_req,
  input  logic [8*N_REQ-1:0]       i_req_byte,
  output logic [N_REQ-1:0]         o_ack,
  output logic                     o_tx_dv,
  output logic [7:0]               o_tx_byte,
  input  logic                     i_tx_done,
  output logic                     o_busy,
  output logic [$clog2(N_REQ)-1:0] o_grant_id,
  output logic                     o_timeout
);

  localparam int GW = $clog2(N_REQ);

  if (N_REQ < 2 || N_REQ > 16) begin : g_bad_n_req
    $error("uart_tx_arbiter: N_REQ must lie in 2..16");
  end
  if (TIMEOUT_CLKS < 2) begin : g_bad_timeout
    $error("uart_tx_arbiter: TIMEOUT_CLKS must be at least 2");
  end

  typedef enum logic {IDLE, WAIT_DONE} state_t;

  state_t        state;
  logic [GW-1:0] last_grant;
  logic [GW-1:0] winner;
  logic [7:0]    win_byte;
  logic          found;

`ifdef UART_ARB_TIMEOUT_EN
  localparam int            CW       = $clog2(TIMEOUT_CLKS) + 1;
  localparam logic [CW-1:0] WD_LIMIT = CW'(TIMEOUT_CLKS - 1);
  logic [CW-1:0] wd_cnt;
`endif

  // Search starts just after the last grant so every requester gets a turn.
  always_comb begin
    int cand;
    found    = 1'b0;
    winner   = last_grant;
    win_byte = 8'h00;
    cand     = 0;
    for (int i = 1; i <= N_REQ; i++) begin
      cand = (int'(last_grant) + i) % N_REQ;
      if (!found && i_req[cand]) begin
        found    = 1'b1;
        winner   = cand[GW-1:0];
        win_byte = i_req_byte[8*cand +: 8];
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state      <= IDLE;
      o_ack      <= '0;
      o_tx_dv    <= 1'b0;
      o_tx_byte  <= 8'h00;
      o_busy     <= 1'b0;
      o_grant_id <= '0;
      last_grant <= GW'(N_REQ - 1);
`ifdef UART_ARB_TIMEOUT_EN
      o_timeout  <= 1'b0;
      wd_cnt     <= '0;
`endif
    end else begin
      o_ack   <= '0;
      o_tx_dv <= 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
      o_timeout <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (found) begin
            o_tx_byte     <= win_byte;
            o_tx_dv       <= 1'b1;
            o_ack[winner] <= 1'b1;
            o_grant_id    <= winner;
            last_grant    <= winner;
            o_busy        <= 1'b1;
            state         <= WAIT_DONE;
`ifdef UART_ARB_TIMEOUT_EN
            wd_cnt        <= '0;
`endif
          end
        end
        // Requests are ignored here; a done on the limit cycle beats the watchdog.
        WAIT_DONE: begin
          if (i_tx_done) begin
            o_busy <= 1'b0;
            state  <= IDLE;
          end
`ifdef UART_ARB_TIMEOUT_EN
          else if (wd_cnt == WD_LIMIT) begin
            o_busy    <= 1'b0;
            o_timeout <= 1'b1;
            state     <= IDLE;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifndef UART_ARB_TIMEOUT_EN
  assign o_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: arbitration, latency, reset mid-transfer and watchdog
// (watchdog checks follow UART_ARB_TIMEOUT_EN, same as the design).
`timescale 1ns/1ps
module tb_uart_tx_arbiter;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] req = '0;
  logic [8*N-1:0] req_byte = '0;
  logic         man_done = 1'b0;
  logic         use_model = 1'b0;

  logic [N-1:0] ack;
  logic         tx_dv;
  logic [7:0]   tx_byte;
  logic         tx_done;
  logic         busy;
  logic [1:0]   grant_id;
  logic         timeout;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.N_REQ(N), .TIMEOUT_CLKS(16)) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_req      (req),
    .i_req_byte (req_byte),
    .o_ack      (ack),
    .o_tx_dv    (tx_dv),
    .o_tx_byte  (tx_byte),
    .i_tx_done  (tx_done),
    .o_busy     (busy),
    .o_grant_id (grant_id),
    .o_timeout  (timeout)
  );

  // Minimal transmitter: 8N1 framing at 4 clocks per bit, one-cycle done after the stop bit.
  logic [9:0] m_sh   = '0;
  int         m_bit  = 0;
  int         m_clk  = 0;
  logic       m_busy = 1'b0;
  logic       m_done = 1'b0;
  logic       serial = 1'b1;

  assign tx_done = use_model ? m_done : man_done;

  always @(posedge clk) begin
    m_done <= 1'b0;
    if (!m_busy) begin
      serial <= 1'b1;
      if (use_model && tx_dv) begin
        m_sh   <= {1'b1, tx_byte, 1'b0};
        m_busy <= 1'b1;
        m_bit  <= 0;
        m_clk  <= 0;
      end
    end else begin
      serial <= m_sh[m_bit];
      if (m_clk == 3) begin
        m_clk <= 0;
        if (m_bit == 9) begin
          m_busy <= 1'b0;
          m_done <= 1'b1;
        end else begin
          m_bit <= m_bit + 1;
        end
      end else begin
        m_clk <= m_clk + 1;
      end
    end
  end

  logic [7:0] rx_sh;
  logic [7:0] rx_q[$];

  initial begin
    forever begin
      @(posedge clk);
      if (use_model && serial === 1'b0) begin
        repeat (2) @(posedge clk);
        for (int b = 0; b < 8; b++) begin
          repeat (4) @(posedge clk);
          rx_sh[b] = serial;
        end
        repeat (4) @(posedge clk);
        rx_q.push_back(rx_sh);
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic finish_xfer();
    man_done = 1'b1;
    tick();
    man_done = 1'b0;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "bench time limit");
  end

  int          order_q[$];
  logic [7:0]  launch_q[$];
  int          dv_cnt;
  int          done_cnt;
  int          cyc;
  int          odd;
  int          exp_order[5] = '{0, 1, 2, 3, 0};
  logic [7:0]  exp_rx[5]    = '{8'h10, 8'h21, 8'h32, 8'h43, 8'h10};

  initial begin
    // Reset state
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    check("rst_ack", 32'(ack), 32'h0);
    check("rst_dv", 32'(tx_dv), 32'h0);
    check("rst_byte", 32'(tx_byte), 32'h00);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_grant", 32'(grant_id), 32'h0);
    check("rst_timeout", 32'(timeout), 32'h0);

    // Single request from requester 2, one-cycle latency
    req      = 4'b0100;
    req_byte = {8'h00, 8'hA5, 8'h00, 8'h00};
    tick();
    check("t1_dv", 32'(tx_dv), 32'h1);
    check("t1_ack", 32'(ack), 32'b0100);
    check("t1_byte", 32'(tx_byte), 32'hA5);
    check("t1_grant", 32'(grant_id), 32'h2);
    check("t1_busy", 32'(busy), 32'h1);
    req = '0;
    tick();
    check("t1_dv_pulse", 32'(tx_dv), 32'h0);
    check("t1_ack_pulse", 32'(ack), 32'h0);
    check("t1_byte_hold", 32'(tx_byte), 32'hA5);
    tick(3);
    check("t1_busy_wait", 32'(busy), 32'h1);
    man_done = 1'b1;
    check("t1_busy_at_done", 32'(busy), 32'h1);
    tick();
    man_done = 1'b0;
    check("t1_busy_after_done", 32'(busy), 32'h0);
    check("t1_grant_kept", 32'(grant_id), 32'h2);
    tick();

    // Done and new requests in the same cycle; last grant is 3
    req      = 4'b1000;
    req_byte = {8'h77, 8'h00, 8'h00, 8'h00};
    tick();
    check("t3_grant3", 32'(grant_id), 32'h3);
    check("t3_ack3", 32'(ack), 32'b1000);
    req = '0;
    tick(2);
    man_done = 1'b1;
    req      = 4'b1001;
    req_byte = {8'h77, 8'h00, 8'h00, 8'h5A};
    tick();
    man_done = 1'b0;
    check("t3_no_dv_d1", 32'(tx_dv), 32'h0);
    check("t3_idle_d1", 32'(busy), 32'h0);
    tick();
    check("t3_dv_d2", 32'(tx_dv), 32'h1);
    check("t3_ack_d2", 32'(ack), 32'b0001);
    check("t3_grant_d2", 32'(grant_id), 32'h0);
    check("t3_byte_d2", 32'(tx_byte), 32'h5A);
    req = '0;
    tick();
    finish_xfer();

    // Reset during WAIT_DONE, then stray done, then normal grant
    req      = 4'b0001;
    req_byte = {8'h00, 8'h00, 8'h66, 8'h33};
    tick();
    check("t4_launch", 32'(tx_dv), 32'h1);
    req = '0;
    tick(2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t4_rst_ack", 32'(ack), 32'h0);
    check("t4_rst_dv", 32'(tx_dv), 32'h0);
    check("t4_rst_byte", 32'(tx_byte), 32'h00);
    check("t4_rst_busy", 32'(busy), 32'h0);
    check("t4_rst_grant", 32'(grant_id), 32'h0);
    man_done = 1'b1;
    tick();
    man_done = 1'b0;
    check("t4_stray_dv", 32'(tx_dv), 32'h0);
    check("t4_stray_busy", 32'(busy), 32'h0);
    tick();
    check("t4_stray_dv2", 32'(tx_dv), 32'h0);
    req = 4'b0010;
    tick();
    check("t4_dv", 32'(tx_dv), 32'h1);
    check("t4_ack", 32'(ack), 32'b0010);
    check("t4_grant", 32'(grant_id), 32'h1);
    check("t4_byte", 32'(tx_byte), 32'h66);
    req = '0;
    tick();
    finish_xfer();

    // All four requesting with the transmitter model attached
    rst = 1'b1;
    tick();
    rst = 1'b0;
    use_model = 1'b1;
    rx_q.delete();
    req      = 4'b1111;
    req_byte = {8'h43, 8'h32, 8'h21, 8'h10};
    dv_cnt   = 0;
    done_cnt = 0;
    cyc      = 0;
    while (dv_cnt < 5 && cyc < 2000) begin
      tick();
      cyc++;
      if (tx_dv) begin
        dv_cnt++;
        order_q.push_back(int'(grant_id));
        launch_q.push_back(tx_byte);
      end
      if (tx_done) done_cnt++;
    end
    req = '0;
    cyc = 0;
    while ((done_cnt < 5 || rx_q.size() < 5) && cyc < 2000) begin
      tick();
      cyc++;
      if (tx_dv) dv_cnt++;
      if (tx_done) done_cnt++;
    end
    tick(10);
    if (tx_dv) dv_cnt++;
    check("t2_dv_count", 32'(dv_cnt), 32'd5);
    check("t2_done_count", 32'(done_cnt), 32'd5);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("t2_order%0d", i),
            (i < order_q.size()) ? 32'(order_q[i]) : 32'hDEAD, 32'(exp_order[i]));
      check($sformatf("t2_launch%0d", i),
            (i < launch_q.size()) ? 32'(launch_q[i]) : 32'hDEAD, 32'(exp_rx[i]));
      check($sformatf("t2_serial%0d", i),
            (i < rx_q.size()) ? 32'(rx_q[i]) : 32'hDEAD, 32'(exp_rx[i]));
    end
    use_model = 1'b0;
    tick(2);

    // Transmitter never answers
    req      = 4'b0001;
    req_byte = {8'h00, 8'h00, 8'h00, 8'h99};
    tick();
    check("t5_launch", 32'(tx_dv), 32'h1);
    check("t5_grant", 32'(grant_id), 32'h0);
`ifdef UART_ARB_TIMEOUT_EN
    odd = 0;
    for (int k = 1; k < 16; k++) begin
      tick();
      if (timeout !== 1'b0 || busy !== 1'b1 || tx_dv !== 1'b0) odd++;
    end
    check("t5_quiet_before_limit", 32'(odd), 32'd0);
    tick();
    check("t5_timeout", 32'(timeout), 32'h1);
    check("t5_busy_fall", 32'(busy), 32'h0);
    tick();
    check("t5_timeout_pulse", 32'(timeout), 32'h0);
    check("t5_relaunch_dv", 32'(tx_dv), 32'h1);
    check("t5_relaunch_ack", 32'(ack), 32'b0001);
    check("t5_relaunch_busy", 32'(busy), 32'h1);
    tick(15);
    req      = '0;
    man_done = 1'b1;
    tick();
    man_done = 1'b0;
    check("t5_done_wins_to", 32'(timeout), 32'h0);
    check("t5_done_wins_busy", 32'(busy), 32'h0);
    tick();
    check("t5_no_late_to", 32'(timeout), 32'h0);
`else
    odd = 0;
    for (int k = 0; k < 1000; k++) begin
      tick();
      if (busy !== 1'b1 || timeout !== 1'b0 || tx_dv !== 1'b0) odd++;
    end
    check("t5_busy_held", 32'(odd), 32'd0);
    check("t5_no_timeout", 32'(timeout), 32'h0);
    req = '0;
    finish_xfer();
    check("t5_release", 32'(busy), 32'h0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
